// File: rtl/wave_capture_trig.sv
// rtl/wave_capture_trig.sv - triggered double-buffered waveform capture into display RAM
// Optional auto-trigger on timeout enabled by defining WAVE_CAPTURE_TRIG_AUTO_TRIG_EN.
module wave_capture_trig #(
    parameter int SAMPLE_W     = 16,
    parameter int OUT_W        = 8,
    parameter int DEPTH_LOG2   = 8,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample_ready,
    input  logic [SAMPLE_W-1:0]   new_sample_in,
    input  logic [1:0]            trig_mode,
    input  logic [SAMPLE_W-1:0]   trig_level,
    input  logic                  wave_display_idle,
    output logic [DEPTH_LOG2:0]   write_address,
    output logic                  write_enable,
    output logic [OUT_W-1:0]      write_sample,
    output logic                  read_index,
`ifdef WAVE_CAPTURE_TRIG_AUTO_TRIG_EN
    output logic                  auto_fired,
`endif
    output logic                  armed
);

    generate
        if (OUT_W > SAMPLE_W) begin : g_bad_out_w
            $error("OUT_W must not exceed SAMPLE_W");
        end
        if (AUTO_TIMEOUT < 1) begin : g_bad_timeout
            $error("AUTO_TIMEOUT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] IDX_LAST = '1;

    state_t                 state, state_n;
    logic [DEPTH_LOG2-1:0]  index, index_n;
    logic                   hist_valid, hist_valid_n;
    logic [SAMPLE_W-1:0]    prev, prev_n;
    logic [DEPTH_LOG2:0]    write_address_n;
    logic                   write_enable_n;
    logic [OUT_W-1:0]       write_sample_n;
    logic                   read_index_n;
    logic                   real_trig;
    logic                   trig;

    logic signed [SAMPLE_W-1:0] p_s, n_s, lvl_s;
    assign p_s   = $signed(prev);
    assign n_s   = $signed(new_sample_in);
    assign lvl_s = $signed(trig_level);

    // Edge conditions need a valid history sample; free-run fires on any sample.
    always_comb begin
        real_trig = 1'b0;
        case (trig_mode)
            2'b00:   real_trig = hist_valid && (p_s < 0) && (n_s >= 0);
            2'b01:   real_trig = hist_valid && (p_s >= 0) && (n_s < 0);
            2'b10:   real_trig = hist_valid && (p_s < lvl_s) && (n_s >= lvl_s);
            default: real_trig = 1'b1;
        endcase
    end

`ifdef WAVE_CAPTURE_TRIG_AUTO_TRIG_EN
    localparam int CNT_W = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] auto_cnt, auto_cnt_n;
    logic             forced_trig;
    logic             auto_fired_n;

    assign forced_trig = !real_trig && (auto_cnt == CNT_LAST);
    assign trig        = real_trig || forced_trig;
`else
    assign trig = real_trig;
`endif

    always_comb begin
        state_n         = state;
        index_n         = index;
        hist_valid_n    = hist_valid;
        prev_n          = prev;
        write_enable_n  = 1'b0;
        write_address_n = write_address;
        write_sample_n  = write_sample;
        read_index_n    = read_index;
`ifdef WAVE_CAPTURE_TRIG_AUTO_TRIG_EN
        auto_cnt_n      = auto_cnt;
        auto_fired_n    = 1'b0;
`endif
        case (state)
            ST_ARMED: begin
                if (new_sample_ready) begin
                    prev_n       = new_sample_in;
                    hist_valid_n = 1'b1;
`ifdef WAVE_CAPTURE_TRIG_AUTO_TRIG_EN
                    auto_cnt_n   = trig ? '0 : auto_cnt + CNT_ONE;
                    auto_fired_n = forced_trig;
`endif
                    if (trig) begin
                        write_enable_n  = 1'b1;
                        write_address_n = {~read_index, {DEPTH_LOG2{1'b0}}};
                        write_sample_n  = new_sample_in[SAMPLE_W-1 -: OUT_W];
                        index_n         = IDX_ONE;
                        state_n         = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    prev_n          = new_sample_in;
                    hist_valid_n    = 1'b1;
                    write_enable_n  = 1'b1;
                    write_address_n = {~read_index, index};
                    write_sample_n  = new_sample_in[SAMPLE_W-1 -: OUT_W];
                    index_n         = index + IDX_ONE;
                    if (index == IDX_LAST) begin
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Samples arriving here are dropped; the display still owns the other half.
                if (wave_display_idle) begin
                    read_index_n = ~read_index;
                    hist_valid_n = 1'b0;
                    state_n      = ST_ARMED;
`ifdef WAVE_CAPTURE_TRIG_AUTO_TRIG_EN
                    auto_cnt_n   = '0;
`endif
                end
            end
            default: begin
                state_n = ST_ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_ARMED;
            index         <= '0;
            hist_valid    <= 1'b0;
            prev          <= '0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
            read_index    <= 1'b0;
        end else begin
            state         <= state_n;
            index         <= index_n;
            hist_valid    <= hist_valid_n;
            prev          <= prev_n;
            write_enable  <= write_enable_n;
            write_address <= write_address_n;
            write_sample  <= write_sample_n;
            read_index    <= read_index_n;
        end
    end

`ifdef WAVE_CAPTURE_TRIG_AUTO_TRIG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auto_cnt   <= '0;
            auto_fired <= 1'b0;
        end else begin
            auto_cnt   <= auto_cnt_n;
            auto_fired <= auto_fired_n;
        end
    end
`endif

    assign armed = (state == ST_ARMED);

endmodule

// File: tb/tb_wave_capture_trig.sv
// tb/tb_wave_capture_trig.sv - scoreboard bench for wave_capture_trig
module tb_wave_capture_trig;

    localparam int SW = 16;
    localparam int OW = 8;
    localparam int DL = 8;
    localparam int AT = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          new_sample_ready;
    logic [SW-1:0] new_sample_in;
    logic [1:0]    trig_mode;
    logic [SW-1:0] trig_level;
    logic          wave_display_idle;
    logic [DL:0]   write_address;
    logic          write_enable;
    logic [OW-1:0] write_sample;
    logic          read_index;
    logic          armed;
`ifdef WAVE_CAPTURE_TRIG_AUTO_TRIG_EN
    logic          auto_fired;
`endif

    always #5 clk = ~clk;

    wave_capture_trig #(
        .SAMPLE_W(SW), .OUT_W(OW), .DEPTH_LOG2(DL), .AUTO_TIMEOUT(AT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .new_sample_ready(new_sample_ready),
        .new_sample_in(new_sample_in),
        .trig_mode(trig_mode),
        .trig_level(trig_level),
        .wave_display_idle(wave_display_idle),
        .write_address(write_address),
        .write_enable(write_enable),
        .write_sample(write_sample),
        .read_index(read_index),
`ifdef WAVE_CAPTURE_TRIG_AUTO_TRIG_EN
        .auto_fired(auto_fired),
`endif
        .armed(armed)
    );

    typedef struct packed {
        logic [DL:0]   addr;
        logic [OW-1:0] data;
        logic          fired;
    } wr_t;

    wr_t  exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic rd      = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_write(input int idx, input logic [OW-1:0] d, input logic f);
        wr_t e;
        e.addr  = {~rd, idx[DL-1:0]};
        e.data  = d;
        e.fired = f;
        exp_q.push_back(e);
    endtask

    // Entered and left on a falling edge so gap=0 gives back-to-back strobes.
    task automatic strobe(input logic [SW-1:0] v, input int gap);
        new_sample_ready = 1'b1;
        new_sample_in    = v;
        @(negedge clk);
        new_sample_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic fill(input int first);
        for (int i = first; i < (1 << DL); i++) begin
            logic [SW-1:0] v;
            v = SW'(i) << 8;
            expect_write(i, v[SW-1 -: OW], 1'b0);
            strobe(v, 0);
        end
    endtask

    task automatic finish_capture(input string tag);
        repeat (3) @(negedge clk);
        rd = ~rd;
        check({tag, "_read_index"}, read_index, rd);
        check({tag, "_armed"}, armed, 1'b1);
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset && write_enable) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", write_enable, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", write_address, e.addr);
                check("wr_data", write_sample, e.data);
`ifdef WAVE_CAPTURE_TRIG_AUTO_TRIG_EN
                check("auto_fired", auto_fired, e.fired);
`endif
            end
        end
    end

    initial begin
        #1ms;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        reset             = 1'b1;
        new_sample_ready  = 1'b0;
        new_sample_in     = '0;
        trig_mode         = 2'b00;
        trig_level        = '0;
        wave_display_idle = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_armed", armed, 1'b1);
        check("rst_we", write_enable, 1'b0);
        check("rst_addr", write_address, '0);
        check("rst_data", write_sample, '0);
        check("rst_read_index", read_index, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Rising zero-cross, first capture into upper half
        strobe(16'hFFFB, 1);
        strobe(16'hFFFF, 0);
        check("zc_armed_before", armed, 1'b1);
        expect_write(0, 8'h12, 1'b0);
        strobe(16'h1234, 0);
        check("zc_armed_capture", armed, 1'b0);
        fill(1);

        // Hand-off held off by a busy display
        repeat (3) @(negedge clk);
        check("wait_read_index", read_index, 1'b0);
        check("wait_armed", armed, 1'b0);
        for (int i = 0; i < 50; i++) strobe(16'h0100, 1);
        check("wait_read_index_hold", read_index, 1'b0);
        wave_display_idle = 1'b1;
        @(negedge clk);
        rd = 1'b1;
        check("handoff_read_index", read_index, rd);
        check("handoff_armed", armed, 1'b1);

        // Stale prev is negative; fresh history must block a false trigger
        strobe(16'd5, 0);
        strobe(16'd7, 0);
        check("fresh_no_trig", armed, 1'b1);
        strobe(16'hFFFE, 0);
        expect_write(0, 8'h00, 1'b0);
        strobe(16'h0000, 0);
        fill(1);
        finish_capture("fresh");

        // Falling zero-cross
        trig_mode = 2'b01;
        strobe(16'd3, 0);
        expect_write(0, 8'hFF, 1'b0);
        strobe(16'hFFFD, 0);
        fill(1);
        finish_capture("fall");

        // Level crossing at 1000
        trig_mode  = 2'b10;
        trig_level = 16'd1000;
        strobe(16'd999, 0);
        expect_write(0, 8'h03, 1'b0);
        strobe(16'd1000, 0);
        fill(1);
        finish_capture("level");

        strobe(16'd1000, 0);
        strobe(16'd1001, 1);
        check("level_no_trig", armed, 1'b1);
        trig_mode = 2'b11;
        expect_write(0, 8'h40, 1'b0);
        strobe(16'h4000, 0);
        fill(1);
        finish_capture("freerun");

        // Reset at index 100 of an active capture
        expect_write(0, 8'h11, 1'b0);
        strobe(16'h1100, 0);
        for (int i = 1; i < 100; i++) begin
            logic [SW-1:0] v;
            v = SW'(i) << 8;
            expect_write(i, v[SW-1 -: OW], 1'b0);
            strobe(v, 0);
        end
        #2;
        reset = 1'b1;
        #1;
        check("midrst_we", write_enable, 1'b0);
        check("midrst_addr", write_address, '0);
        check("midrst_data", write_sample, '0);
        check("midrst_read_index", read_index, 1'b0);
        check("midrst_armed", armed, 1'b1);
        check("midrst_queue", exp_q.size(), 0);
        rd = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        trig_mode = 2'b00;
        @(negedge clk);
        strobe(16'hFFFF, 0);
        expect_write(0, 8'h00, 1'b0);
        strobe(16'h0001, 0);
        fill(1);
        finish_capture("postrst");

        // Free-run fires on the very first sample after arming
        trig_mode = 2'b11;
        expect_write(0, 8'h7F, 1'b0);
        strobe(16'h7F00, 0);
        check("freerun_first", armed, 1'b0);
        fill(1);
        finish_capture("freerun_first");

`ifdef WAVE_CAPTURE_TRIG_AUTO_TRIG_EN
        trig_mode = 2'b00;
        for (int i = 0; i < AT - 1; i++) strobe(16'd100, 0);
        check("auto_armed_before", armed, 1'b1);
        expect_write(0, 8'h00, 1'b1);
        strobe(16'd100, 0);
        check("auto_armed_after", armed, 1'b0);
        fill(1);
        finish_capture("auto");
`endif

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
